push_driver: RTL
================

# push_driver

Command sequencer for the push-box grid walker. Accepts move commands over a valid/ready stream and turns each one into a one-cycle `dx`/`dy` step for the walker. It samples the walker's `hit` and `out` feedback, counts moves and collisions, and stops when the goal is reached or the move budget runs out. It sits between the command source (testbench or script ROM) and the walker.

## Interface
- `MAX_MOVES`, 15: move budget per run. Must satisfy 1 ≤ MAX_MOVES ≤ 2^CNT_W − 1.
- `CNT_W`, 4: width of both counters.

- `clk`  in  1  system clock, rising edge.
- `clr_n`  in  1  asynchronous, active-low reset.
- `start`  in  1  begin a run; level-sampled; honoured only in IDLE or DONE.
- `cmd_valid`  in  1  command present.
- `cmd`  in  2  bit0 = x step, bit1 = y step; 00 = no-op.
- `cmd_ready`  out  1  driver can accept a command.
- `walk_clr`  out  1  clear to walker (active-high); returns it to (0,0).
- `dx`  out  1  x step to walker.
- `dy`  out  1  y step to walker.
- `hit`  in  1  walker collision flag; combinational from walker state plus `dx`/`dy`.
- `goal`  in  1  walker `out`; Moore, reflects current position.
- `move_cnt`  out  CNT_W  steps issued this run.
- `hit_cnt`  out  CNT_W  steps that collided.
- `busy`  out  1  run in progress.
- `done`  out  1  goal reached; sticky until next start.
- `fail`  out  1  budget exhausted without goal; sticky until next start.

## Operation
- **Reset values** (any time `clr_n` = 0): state IDLE; `cmd_ready`, `walk_clr`, `dx`, `dy`, `busy`, `done`, `fail` = 0; counters = 0; command latch = 00.
- **Output decode:** all outputs are Moore, decoded from state and registers only. No combinational path from inputs to outputs.
- **IDLE**
  - `start` = 1 → CLR.
  - Otherwise stay in IDLE.
- **CLR** (1 cycle)
  - `walk_clr` = 1, `busy` = 1.
  - Counters, `done` and `fail` clear on exit.
  - Always → WAIT.
- **WAIT**
  - `cmd_ready` = 1, `busy` = 1.
  - On `cmd_valid` & `cmd_ready` with `cmd` ≠ 00: latch `cmd` → STEP.
  - On `cmd` = 00: command is consumed and discarded; stay in WAIT; counters unchanged.
- **STEP** (1 cycle)
  - `dx` = latched bit0, `dy` = latched bit1, `cmd_ready` = 0.
  - At the exit edge: `move_cnt` += 1; `hit_cnt` += `hit`.
  - → CHECK.
- **CHECK** (1 cycle)
  - `dx` = `dy` = 0; the walker has already updated its position.
  - `goal` = 1 → DONE and set `done`. Goal takes priority over budget.
  - Else `move_cnt` == MAX_MOVES → DONE and set `fail`.
  - Else → WAIT.
- **DONE**
  - `busy` = 0; `done` or `fail` held; counters held.
  - `start` = 1 → CLR.
- **Ignored inputs:** `start` in CLR, WAIT, STEP or CHECK.
- **Counter rules:** plain unsigned increment; cannot wrap, because of the parameter constraint and because `hit_cnt` ≤ `move_cnt`.
- **Flag exclusivity:** `done` and `fail` are never 1 together.

## Timing
- Accept edge k (WAIT, handshake).
- Cycle k+1 is STEP: `dx`/`dy` high; the walker commits at edge k+2.
- Cycle k+2 is CHECK: `goal` is sampled.
- Cycle k+3 is WAIT again, or DONE.
- Throughput: one step per 3 cycles; `cmd_ready` is low for exactly 2 cycles after each non-no-op accept.
- Run start: `start` seen at edge s puts the driver in CLR during cycle s+1 and WAIT from s+2. `walk_clr` is high for exactly cycle s+1.
- Reset mid-run (`clr_n` low in any state) takes effect immediately. `dx`/`dy` drop the same instant. The walker is not cleared by `clr_n` through this block.

## Test plan
Common setup: walker with goal (1,2) and trap (1,0); grid limits x ≤ 1, y ≤ 2.

1. Start, then commands 10, 10, 01 back-to-back → path (0,1), (0,2), (1,2). Required: `done` = 1 on the 3rd CHECK exit, `move_cnt` = 3, `hit_cnt` = 0, `fail` = 0. Exactly 3 one-cycle `dx`/`dy` pulses, `cmd_ready` pattern 1,0,0 repeating.
2. Start, then command 01 → walker at trap (1,0). Required: `hit` = 1 during STEP, position stays (0,0), `hit_cnt` = 1, `move_cnt` = 1, state returns to WAIT.
3. MAX_MOVES = 4; commands 11, 11, 11, 11 → first step to (1,1), then 3 out-of-bounds hits. Required: `fail` = 1, `done` = 0, `move_cnt` = 4, `hit_cnt` = 3; further `cmd_valid` is not accepted.
4. Commands 00, 00, then 10, with `cmd_valid` low for 5 cycles between commands. Required: both no-ops accepted with no STEP and counters at 0; WAIT holds `cmd_ready` = 1 through the gap; 10 gives `move_cnt` = 1.
5. `clr_n` pulsed low during STEP. Required: `dx`/`dy`, `busy` and counters go to 0 asynchronously; state IDLE; `cmd_ready` = 0. A `start` pulse during WAIT of a later run does not re-trigger CLR.
6. After test 1 ends in DONE, pulse `start`. Required: one `walk_clr` cycle, `done` clears, `move_cnt` = `hit_cnt` = 0, then the replayed sequence from test 1 reaches `done` again.

Source files
------------

// File: rtl/push_driver_if.sv
// Command/feedback bundle between the command source, push_driver and the walker.
//
// Handshake: a command transfers on a rising clk edge where cmd_valid and
// cmd_ready are both 1. cmd_ready is a registered-state decode and never
// depends on cmd_valid. The source holds cmd stable while cmd_valid is high.
// A cmd of 2'b00 is consumed like any other command but produces no step.
interface push_driver_if #(
    parameter int CNT_W = 4
);
    logic             start;
    logic             cmd_valid;
    logic [1:0]       cmd;
    logic             cmd_ready;
    logic             walk_clr;
    logic             dx;
    logic             dy;
    logic             hit;
    logic             goal;
    logic [CNT_W-1:0] move_cnt;
    logic [CNT_W-1:0] hit_cnt;
    logic             busy;
    logic             done;
    logic             fail;
    logic [2:0]       dbg_state;

    // Command source / walker side
    modport master (
        output start, cmd_valid, cmd, hit, goal,
        input  cmd_ready, walk_clr, dx, dy, move_cnt, hit_cnt,
               busy, done, fail, dbg_state
    );

    // push_driver side
    modport slave (
        input  start, cmd_valid, cmd, hit, goal,
        output cmd_ready, walk_clr, dx, dy, move_cnt, hit_cnt,
               busy, done, fail, dbg_state
    );
endinterface

// File: rtl/push_driver.sv
// Command sequencer for the push-box grid walker.
// Each non-zero command becomes a one-cycle dx/dy step, followed by a check
// cycle in which the walker's goal flag is sampled. Moves and collisions are
// counted; the run ends on goal (done) or when the move budget is spent (fail).
// All outputs are decoded from state and registers only.
// MAX_MOVES must lie in 1 .. 2**CNT_W-1 so the counters never wrap.
module push_driver #(
    parameter int MAX_MOVES = 15,
    parameter int CNT_W     = 4
) (
    input  logic         clk,
    input  logic         clr_n,
    push_driver_if.slave bus
);
    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_CLR   = 3'd1,
        S_WAIT  = 3'd2,
        S_STEP  = 3'd3,
        S_CHECK = 3'd4,
        S_DONE  = 3'd5
    } state_t;

    localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_MOVES);

    state_t           r_state;
    state_t           w_state_nxt;
    logic [1:0]       r_cmd;
    logic [CNT_W-1:0] r_move_cnt;
    logic [CNT_W-1:0] r_hit_cnt;
    logic             r_done;
    logic             r_fail;

    logic             w_accept;
    logic             w_step_cmd;
    logic             w_budget_out;

    assign w_accept     = (r_state == S_WAIT) && bus.cmd_valid;
    assign w_step_cmd   = w_accept && (bus.cmd != 2'b00);
    assign w_budget_out = (r_move_cnt == MAX_CNT);

    // State register; clr_n forces IDLE, which also drops every decoded output
    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic and Moore output decode
    always_comb begin
        w_state_nxt   = r_state;
        bus.cmd_ready = 1'b0;
        bus.walk_clr  = 1'b0;
        bus.dx        = 1'b0;
        bus.dy        = 1'b0;
        bus.busy      = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (bus.start) w_state_nxt = S_CLR;
            end
            S_CLR: begin
                bus.walk_clr = 1'b1;
                bus.busy     = 1'b1;
                w_state_nxt  = S_WAIT;
            end
            S_WAIT: begin
                bus.cmd_ready = 1'b1;
                bus.busy      = 1'b1;
                if (w_step_cmd) w_state_nxt = S_STEP;
            end
            S_STEP: begin
                bus.dx      = r_cmd[0];
                bus.dy      = r_cmd[1];
                bus.busy    = 1'b1;
                w_state_nxt = S_CHECK;
            end
            S_CHECK: begin
                bus.busy = 1'b1;
                // Goal wins over an exhausted budget on the same move
                if (bus.goal || w_budget_out) w_state_nxt = S_DONE;
                else                          w_state_nxt = S_WAIT;
            end
            S_DONE: begin
                if (bus.start) w_state_nxt = S_CLR;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // Command latch, counters and sticky result flags
    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            r_cmd      <= 2'b00;
            r_move_cnt <= '0;
            r_hit_cnt  <= '0;
            r_done     <= 1'b0;
            r_fail     <= 1'b0;
        end else begin
            case (r_state)
                S_CLR: begin
                    r_move_cnt <= '0;
                    r_hit_cnt  <= '0;
                    r_done     <= 1'b0;
                    r_fail     <= 1'b0;
                end
                S_WAIT: begin
                    if (w_step_cmd) r_cmd <= bus.cmd;
                end
                S_STEP: begin
                    // hit reflects the walker's reaction to the step driven now
                    r_move_cnt <= r_move_cnt + 1'b1;
                    r_hit_cnt  <= r_hit_cnt + CNT_W'(bus.hit);
                end
                S_CHECK: begin
                    if (bus.goal)        r_done <= 1'b1;
                    else if (w_budget_out) r_fail <= 1'b1;
                end
                default: begin
                end
            endcase
        end
    end

    assign bus.move_cnt  = r_move_cnt;
    assign bus.hit_cnt   = r_hit_cnt;
    assign bus.done      = r_done;
    assign bus.fail      = r_fail;
    assign bus.dbg_state = r_state;
endmodule
